seg7_hex_scanner: RTL
=====================

Name: seg7_hex_scanner

Overview:
- Consumer stage in the receive (B) clock domain, directly downstream of the clock-domain-crossing handler.
- Takes the 16-bit word delivered on the B side and shows it as four hex digits on the board's multiplexed 7-segment display.
- Runs a prescaled digit-scan state machine with anti-ghosting blanking.
- Double-buffers the value so each scan frame shows one coherent word.

Parameters:
- SCAN_DIV, 1024: CLK cycles each digit is selected; must be at least 2.
- BLANK_CYC, 4: cycles at the start of each digit slot during which all enables are off; must be less than SCAN_DIV.

Ports:
- CLK  input  1  single clock (B-domain clock).
- RST_N  input  1  asynchronous, active-low reset.
- DATA_IN  input  16  word from the CDC handler's B-side output.
- DATA_VLD  input  1  one-cycle strobe; DATA_IN is valid in that cycle.
- DS_EN  output  4  one-hot digit enable, active-high; bit 0 = least significant digit.
- DS_SEG  output  7  segment drive, active-high; bit0=a, bit1=b, …, bit6=g.

Behaviour:
- Reset (async assert, sync release): pending=0, shadow=0, prescaler=0, digit index=0, DS_EN=4'b0000, DS_SEG=7'b0000000.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On each wrap, the digit index advances 0→1→2→3→0.
- Slot phase:
  - While prescaler < BLANK_CYC, the slot is blanked and DS_EN=0.
  - Otherwise DS_EN has only bit[index] set.
- Output timing:
  - DS_EN and DS_SEG are registered; they reflect counter state with 1 cycle latency.
  - DS_SEG is driven with the decoded nibble even while blanked.
  - DS_SEG for digit i = decode(shadow[4i+3:4i]).
- Decode codes (g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Capture:
  - When DATA_VLD=1, pending <= DATA_IN.
  - Back-to-back strobes: the last one wins.
- Frame boundary (the digit index wraps 3→0):
  - shadow <= DATA_VLD ? DATA_IN : pending, so a simultaneous strobe is displayed immediately.
  - Shadow never changes mid-frame, so digits of different words are never mixed.
- Latency:
  - A new word appears on digit 0 at most 4*SCAN_DIV + BLANK_CYC + 1 cycles after DATA_VLD.
- Reset mid-scan: all state returns to reset values at once; the displayed value is lost. After release, scanning restarts at digit 0 with shadow=0.
- DATA_VLD during reset: ignored.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Each digit above the most significant nonzero nibble of shadow has its DS_EN bit forced to 0 for the whole slot.
  - The slot timing is unchanged.
  - Digit 0 is always shown, so 0x0000 shows a single "0".
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Shared package (seg7_pkg):
  - NUM_DIGITS=4.
  - Segment bit-index constants SEG_A..SEG_G.
  - The 16-entry hex→segment constant table.
  - Typedef for the 2-bit digit index.
- Sub-module hex_to_seg7: purely combinational 4-bit nibble → 7-bit segment decoder. It is instantiated once and fed by a mux on the digit index.

Test Plan:
Bench parameters: SCAN_DIV=8, BLANK_CYC=2.
1. Reset check: RST_N low for 5 cycles → DS_EN=0000, DS_SEG=0000000. After release, the first enable is DS_EN=0001 on cycle 3 (BLANK_CYC+1).
2. Basic display: DATA_VLD with 0xABBA, then two full frames → slots show the codes for A(d0)=1110111, B(d1)=1111100, B(d2)=1111100, A(d3)=1110111. Each enable is high for 6 of every 8 cycles.
3. Coherence: strobe 0xACDC in the middle of digit 2 → digits 2 and 3 still show 0xABBA's nibbles. The next frame shows C,D,C,A.
4. Boundary collision and overwrite:
   - Strobe 0x1234 exactly on the 3→0 wrap → the frame starting then shows 4,3,2,1.
   - Strobes of 0x1111 then 0x2222 in consecutive cycles → only 0x2222 is ever displayed.
5. Async reset mid-scan: assert RST_N during digit 2 between CLK edges → outputs go to zero with no clock edge. After release, scanning restarts at digit 0 showing 0000.
6. With SEG7_LEADING_ZERO_BLANK_EN defined:
   - 0x00F0 → only DS_EN bits 0 and 1 are ever asserted.
   - 0x0000 → only bit 0 is asserted, showing 0111111.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment hex scanner.
//   NUM_DIGITS   - number of multiplexed digits on the display
//   SEG_A..SEG_G - bit positions of each segment in a 7-bit segment word
//   HEX_SEG      - nibble -> segment code table (bit6=g .. bit0=a, active-high)
//   digit_idx_t  - digit index, doubles as the scan state encoding
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } digit_idx_t;

   // Leftmost entry is index 15 (F), rightmost is index 0.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b1110001,  // F
      7'b1111001,  // E
      7'b1011110,  // d
      7'b0111001,  // C
      7'b1111100,  // b
      7'b1110111,  // A
      7'b1101111,  // 9
      7'b1111111,  // 8
      7'b0000111,  // 7
      7'b1111101,  // 6
      7'b1101101,  // 5
      7'b1100110,  // 4
      7'b1001111,  // 3
      7'b1011011,  // 2
      7'b0000110,  // 1
      7'b0111111   // 0
   };

endpackage

// File: rtl/seg7_hex_scanner_if.sv
// seg7_hex_scanner_if: data-in / display-out bundle of the hex scanner.
//   DATA_IN  [15:0] word from the CDC handler's B-side output
//   DATA_VLD        one-cycle strobe qualifying DATA_IN
//   DS_EN    [3:0]  one-hot digit enable, active-high, bit0 = LSD
//   DS_SEG   [6:0]  segment drive, active-high, bit0=a .. bit6=g
// master = upstream/board side, slave = the scanner.
interface seg7_hex_scanner_if;
   import seg7_pkg::*;

   logic [15:0]           DATA_IN;
   logic                  DATA_VLD;
   logic [NUM_DIGITS-1:0] DS_EN;
   logic [6:0]            DS_SEG;

   modport master (output DATA_IN, output DATA_VLD, input DS_EN, input DS_SEG);
   modport slave  (input DATA_IN, input DATA_VLD, output DS_EN, output DS_SEG);

endinterface

// File: rtl/seg7_hex_scanner_hex_to_seg7.sv
// hex_to_seg7: combinational nibble -> 7-segment decoder.
//   i_nib [3:0] hex digit
//   o_seg [6:0] segment code, active-high, bit0=a .. bit6=g
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = HEX_SEG[i_nib];
   end

endmodule

// File: rtl/seg7_hex_scanner.sv
// seg7_hex_scanner: shows a 16-bit word as four hex digits on a multiplexed
// 7-segment display, B clock domain.
//   CLK    single clock
//   RST_N  asynchronous active-low reset
//   bus    seg7_hex_scanner_if.slave (DATA_IN, DATA_VLD in; DS_EN, DS_SEG out)
// Parameters: SCAN_DIV (cycles per digit slot, >= 2),
//             BLANK_CYC (blanked cycles at slot start, < SCAN_DIV).
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: suppress enables of digits above
// the most significant nonzero nibble (digit 0 always shown).
module seg7_hex_scanner
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 1024,
   parameter int unsigned BLANK_CYC = 4
) (
   input  logic                CLK,
   input  logic                RST_N,
   seg7_hex_scanner_if.slave   bus
);

   localparam int unsigned PW = $clog2(SCAN_DIV);

   logic [PW-1:0]         r_presc;
   digit_idx_t            r_digit;
   digit_idx_t            w_digit_nxt;
   logic                  w_wrap;
   logic                  w_frame_end;
   logic [15:0]           r_pending;
   logic [15:0]           r_shadow;
   logic [3:0]            w_nib;
   logic [6:0]            w_seg;
   logic [NUM_DIGITS-1:0] w_en_mask;
   logic [NUM_DIGITS-1:0] w_en_nxt;
   logic [NUM_DIGITS-1:0] r_ds_en;
   logic [6:0]            r_ds_seg;

   assign w_wrap      = (r_presc == PW'(SCAN_DIV - 1));
   assign w_frame_end = w_wrap && (r_digit == DIG3);

   // Slot prescaler
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_presc <= '0;
      end else if (w_wrap) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // Digit-scan state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_digit <= DIG0;
      end else begin
         r_digit <= w_digit_nxt;
      end
   end

   // Digit-scan next state: advance one digit per prescaler wrap
   always_comb begin
      w_digit_nxt = r_digit;
      if (w_wrap) begin
         case (r_digit)
            DIG0:    w_digit_nxt = DIG1;
            DIG1:    w_digit_nxt = DIG2;
            DIG2:    w_digit_nxt = DIG3;
            default: w_digit_nxt = DIG0;
         endcase
      end
   end

   // Double buffer: pending follows every strobe, shadow only reloads at the
   // frame boundary so a frame never mixes two words. A strobe landing on the
   // boundary bypasses pending so it is shown without waiting a frame.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pending <= '0;
         r_shadow  <= '0;
      end else begin
         if (bus.DATA_VLD) begin
            r_pending <= bus.DATA_IN;
         end
         if (w_frame_end) begin
            r_shadow <= bus.DATA_VLD ? bus.DATA_IN : r_pending;
         end
      end
   end

   always_comb begin
      case (r_digit)
         DIG0:    w_nib = r_shadow[3:0];
         DIG1:    w_nib = r_shadow[7:4];
         DIG2:    w_nib = r_shadow[11:8];
         default: w_nib = r_shadow[15:12];
      endcase
   end

   hex_to_seg7 u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   always_comb begin
      w_en_mask    = '0;
      w_en_mask[0] = 1'b1;
      w_en_mask[1] = |r_shadow[15:4];
      w_en_mask[2] = |r_shadow[15:8];
      w_en_mask[3] = |r_shadow[15:12];
   end
`else
   always_comb begin
      w_en_mask = '1;
   end
`endif

   always_comb begin
      w_en_nxt = '0;
      if (r_presc >= PW'(BLANK_CYC)) begin
         w_en_nxt = (NUM_DIGITS'(1) << r_digit) & w_en_mask;
      end
   end

   // Registered display drive; segments keep the decoded value while blanked
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_ds_en  <= '0;
         r_ds_seg <= '0;
      end else begin
         r_ds_en  <= w_en_nxt;
         r_ds_seg <= w_seg;
      end
   end

   assign bus.DS_EN  = r_ds_en;
   assign bus.DS_SEG = r_ds_seg;

endmodule
